// File: rtl/csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// csr_trap_sequencer
//
// Arbitrates the single CSR-file write port between three requesters:
// CSR-instruction writes, supervisor trap entry (four writes: sepc, scause,
// stval, sstatus) and sret (one write: sstatus). After a trap or sret
// completes, the block issues a one-cycle PC redirect to fetch.
//
// Ports
//   i_clk, i_rst_n        clock (rising edge), async active-low reset
//   i_csr_req/addr/wdata  CSR-instruction write request (level, held to ack)
//   i_trap_req/pc/cause/
//   i_trap_tval/priv_s    trap-entry request and operands (latched on accept)
//   i_sret_req            sret request (level, held to ack)
//   i_sstatus/stvec/sepc  live CSR values read back from the CSR file
//   o_csr_data/select/load  CSR-file write port
//   o_csr_ack/trap_ack/sret_ack  one-cycle acceptance pulses
//   o_busy                high whenever the sequencer is not IDLE
//   o_redirect/redirect_pc  one-cycle fetch redirect and its target
//
// Every output is decoded from the state register, the latched operands and
// the live CSR values; request inputs only steer the next-state logic.
// -----------------------------------------------------------------------------
module csr_trap_sequencer #(
  parameter int unsigned TRAP_WRITES = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_csr_req,
  input  logic [11:0] i_csr_addr,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_trap_req,
  input  logic [31:0] i_trap_pc,
  input  logic [31:0] i_trap_cause,
  input  logic [31:0] i_trap_tval,
  input  logic        i_trap_priv_s,
  input  logic        i_sret_req,
  input  logic [31:0] i_sstatus,
  input  logic [31:0] i_stvec,
  input  logic [31:0] i_sepc,
  output logic [31:0] o_csr_data,
  output logic [11:0] o_csr_select,
  output logic        o_csr_load,
  output logic        o_csr_ack,
  output logic        o_trap_ack,
  output logic        o_sret_ack,
  output logic        o_busy,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc
);

  // IDLE, WR_INSTR, one state per trap write, T_REDIR, R_SSTATUS, R_REDIR.
  localparam int unsigned NumStates = TRAP_WRITES + 5;
  localparam int unsigned StateW    = $clog2(NumStates);

  localparam logic [11:0] CsrSstatus = 12'h100;
  localparam logic [11:0] CsrSepc    = 12'h141;
  localparam logic [11:0] CsrScause  = 12'h142;
  localparam logic [11:0] CsrStval   = 12'h143;

  localparam int unsigned SieBit  = 1;
  localparam int unsigned SpieBit = 5;
  localparam int unsigned SppBit  = 8;

  typedef enum logic [StateW-1:0] {
    IDLE,
    WR_INSTR,
    T_SEPC,
    T_SCAUSE,
    T_STVAL,
    T_SSTATUS,
    T_REDIR,
    R_SSTATUS,
    R_REDIR
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] trap_pc_q, trap_pc_d;
  logic [31:0] trap_cause_q, trap_cause_d;
  logic [31:0] trap_tval_q, trap_tval_d;
  logic        trap_priv_s_q, trap_priv_s_d;
  logic [11:0] csr_addr_q, csr_addr_d;
  logic [31:0] csr_wdata_q, csr_wdata_d;

  logic [31:0] trap_sstatus;
  logic [31:0] sret_sstatus;

  // Low address bits of the redirect sources are forced to zero.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_stvec[1:0], i_sepc[0]};

  // ---------------------------------------------------------------------------
  // State and operand registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand registers are reset along with the state even though
  // they are only observed in write states; this keeps them X-free after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      trap_pc_q     <= '0;
      trap_cause_q  <= '0;
      trap_tval_q   <= '0;
      trap_priv_s_q <= 1'b0;
      csr_addr_q    <= '0;
      csr_wdata_q   <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q       <= state_d;
      trap_pc_q     <= trap_pc_d;
      trap_cause_q  <= trap_cause_d;
      trap_tval_q   <= trap_tval_d;
      trap_priv_s_q <= trap_priv_s_d;
      csr_addr_q    <= csr_addr_d;
      csr_wdata_q   <= csr_wdata_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic and arbitration (IDLE only; trap > sret > CSR write)
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would infer a latch.
    state_d       = state_q;
    trap_pc_d     = trap_pc_q;
    trap_cause_d  = trap_cause_q;
    trap_tval_d   = trap_tval_q;
    trap_priv_s_d = trap_priv_s_q;
    csr_addr_d    = csr_addr_q;
    csr_wdata_d   = csr_wdata_q;

    case (state_q)
      IDLE: begin
        if (i_trap_req) begin
          trap_pc_d     = i_trap_pc;
          trap_cause_d  = i_trap_cause;
          trap_tval_d   = i_trap_tval;
          trap_priv_s_d = i_trap_priv_s;
          state_d       = T_SEPC;
        end else if (i_sret_req) begin
          state_d = R_SSTATUS;
        end else if (i_csr_req) begin
          csr_addr_d  = i_csr_addr;
          csr_wdata_d = i_csr_wdata;
          state_d     = WR_INSTR;
        end
      end
      WR_INSTR:  state_d = IDLE;
      T_SEPC:    state_d = T_SCAUSE;
      T_SCAUSE:  state_d = T_STVAL;
      T_STVAL:   state_d = T_SSTATUS;
      T_SSTATUS: state_d = T_REDIR;
      T_REDIR:   state_d = IDLE;
      R_SSTATUS: state_d = R_REDIR;
      R_REDIR:   state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // sstatus updates, computed from the live value the CSR file presents
  // ---------------------------------------------------------------------------
  always_comb begin
    trap_sstatus          = i_sstatus;
    trap_sstatus[SpieBit] = i_sstatus[SieBit];
    trap_sstatus[SieBit]  = 1'b0;
    trap_sstatus[SppBit]  = trap_priv_s_q;

    sret_sstatus          = i_sstatus;
    sret_sstatus[SieBit]  = i_sstatus[SpieBit];
    sret_sstatus[SpieBit] = 1'b1;
    sret_sstatus[SppBit]  = 1'b0;
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    o_csr_data    = '0;
    o_csr_select  = '0;
    o_csr_load    = 1'b0;
    o_csr_ack     = 1'b0;
    o_trap_ack    = 1'b0;
    o_sret_ack    = 1'b0;
    o_busy        = (state_q != IDLE);
    o_redirect    = 1'b0;
    o_redirect_pc = '0;

    case (state_q)
      WR_INSTR: begin
        o_csr_load   = 1'b1;
        o_csr_select = csr_addr_q;
        o_csr_data   = csr_wdata_q;
        o_csr_ack    = 1'b1;
      end
      T_SEPC: begin
        // First cycle after acceptance: ack coincides with the sepc write.
        o_trap_ack   = 1'b1;
        o_csr_load   = 1'b1;
        o_csr_select = CsrSepc;
        o_csr_data   = trap_pc_q;
      end
      T_SCAUSE: begin
        o_csr_load   = 1'b1;
        o_csr_select = CsrScause;
        o_csr_data   = trap_cause_q;
      end
      T_STVAL: begin
        o_csr_load   = 1'b1;
        o_csr_select = CsrStval;
        o_csr_data   = trap_tval_q;
      end
      T_SSTATUS: begin
        o_csr_load   = 1'b1;
        o_csr_select = CsrSstatus;
        o_csr_data   = trap_sstatus;
      end
      T_REDIR: begin
        // Direct mode only: the stvec mode bits are ignored.
        o_redirect    = 1'b1;
        o_redirect_pc = {i_stvec[31:2], 2'b00};
      end
      R_SSTATUS: begin
        o_sret_ack   = 1'b1;
        o_csr_load   = 1'b1;
        o_csr_select = CsrSstatus;
        o_csr_data   = sret_sstatus;
      end
      R_REDIR: begin
        // sepc was written long before this read, so the live value is current.
        o_redirect    = 1'b1;
        o_redirect_pc = {i_sepc[31:1], 1'b0};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// -----------------------------------------------------------------------------
// tb_csr_trap_sequencer
//
// Scoreboard bench: each stimulus task pushes the events it expects (acks,
// CSR-port writes, redirects, with the cycle gap from the previous event),
// and a negedge monitor pops and compares every event the DUT produces.
// -----------------------------------------------------------------------------
module tb_csr_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        csr_req;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic        trap_req;
  logic [31:0] trap_pc;
  logic [31:0] trap_cause;
  logic [31:0] trap_tval;
  logic        trap_priv_s;
  logic        sret_req;
  logic [31:0] sstatus;
  logic [31:0] stvec;
  logic [31:0] sepc;

  logic [31:0] o_csr_data;
  logic [11:0] o_csr_select;
  logic        o_csr_load;
  logic        o_csr_ack;
  logic        o_trap_ack;
  logic        o_sret_ack;
  logic        o_busy;
  logic        o_redirect;
  logic [31:0] o_redirect_pc;

  csr_trap_sequencer #(.TRAP_WRITES(4)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_csr_req     (csr_req),
    .i_csr_addr    (csr_addr),
    .i_csr_wdata   (csr_wdata),
    .i_trap_req    (trap_req),
    .i_trap_pc     (trap_pc),
    .i_trap_cause  (trap_cause),
    .i_trap_tval   (trap_tval),
    .i_trap_priv_s (trap_priv_s),
    .i_sret_req    (sret_req),
    .i_sstatus     (sstatus),
    .i_stvec       (stvec),
    .i_sepc        (sepc),
    .o_csr_data    (o_csr_data),
    .o_csr_select  (o_csr_select),
    .o_csr_load    (o_csr_load),
    .o_csr_ack     (o_csr_ack),
    .o_trap_ack    (o_trap_ack),
    .o_sret_ack    (o_sret_ack),
    .o_busy        (o_busy),
    .o_redirect    (o_redirect),
    .o_redirect_pc (o_redirect_pc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Checking and scoreboard
  // ---------------------------------------------------------------------------
  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int last_cyc    = 0;

  typedef enum int {EV_TRAP_ACK, EV_SRET_ACK, EV_CSR_ACK, EV_WRITE, EV_REDIR} ev_kind_e;

  typedef struct {
    ev_kind_e    kind;
    logic [11:0] sel;
    logic [31:0] data;
    int          gap;   // cycles since previous event, -1 = don't care
    string       tag;
  } exp_ev_t;

  exp_ev_t exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input ev_kind_e k, input logic [11:0] s, input logic [31:0] d,
                      input int gap, input string tag);
    exp_ev_t e;
    e.kind = k;
    e.sel  = s;
    e.data = d;
    e.gap  = gap;
    e.tag  = tag;
    exp_q.push_back(e);
  endtask

  task automatic push_trap(input string tag, input int first_gap,
                           input logic [31:0] pc, input logic [31:0] cause,
                           input logic [31:0] tval, input logic [31:0] new_ss,
                           input logic [31:0] target);
    push(EV_TRAP_ACK, 12'h000, 32'h0, first_gap, {tag, ".ack"});
    push(EV_WRITE,    12'h141, pc,     0, {tag, ".sepc"});
    push(EV_WRITE,    12'h142, cause,  1, {tag, ".scause"});
    push(EV_WRITE,    12'h143, tval,   1, {tag, ".stval"});
    push(EV_WRITE,    12'h100, new_ss, 1, {tag, ".sstatus"});
    push(EV_REDIR,    12'h000, target, 1, {tag, ".redir"});
  endtask

  task automatic push_sret(input string tag, input int first_gap,
                           input logic [31:0] new_ss, input logic [31:0] target);
    push(EV_SRET_ACK, 12'h000, 32'h0,  first_gap, {tag, ".ack"});
    push(EV_WRITE,    12'h100, new_ss, 0, {tag, ".sstatus"});
    push(EV_REDIR,    12'h000, target, 1, {tag, ".redir"});
  endtask

  task automatic push_csr(input string tag, input int first_gap,
                          input logic [11:0] a, input logic [31:0] d);
    push(EV_CSR_ACK, 12'h000, 32'h0, first_gap, {tag, ".ack"});
    push(EV_WRITE,   a,       d,     0, {tag, ".write"});
  endtask

  task automatic observe(input ev_kind_e k, input logic [11:0] s, input logic [31:0] d);
    exp_ev_t e;
    if (exp_q.size() == 0) begin
      check($sformatf("unexpected_%s", k.name()), 96'(1), 96'(0));
      return;
    end
    e = exp_q.pop_front();
    check({e.tag, ".kind"}, 96'(int'(k)), 96'(int'(e.kind)));
    if (e.kind == EV_WRITE) begin
      check({e.tag, ".select"}, 96'(s), 96'(e.sel));
      check({e.tag, ".data"},   96'(d), 96'(e.data));
    end
    if (e.kind == EV_REDIR) check({e.tag, ".pc"}, 96'(d), 96'(e.data));
    if (e.gap >= 0) check({e.tag, ".gap"}, 96'(cyc - last_cyc), 96'(e.gap));
    last_cyc = cyc;
  endtask

  // Monitor samples mid-cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_trap_ack) observe(EV_TRAP_ACK, 12'h000, 32'h0);
      if (o_sret_ack) observe(EV_SRET_ACK, 12'h000, 32'h0);
      if (o_csr_ack)  observe(EV_CSR_ACK,  12'h000, 32'h0);
      if (o_csr_load) observe(EV_WRITE, o_csr_select, o_csr_data);
      else            check("idle_port_zero", 96'({o_csr_select, o_csr_data}), 96'(0));
      if (o_redirect) observe(EV_REDIR, 12'h000, o_redirect_pc);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  function automatic logic ack_of(input int which);
    case (which)
      0:       return o_trap_ack;
      1:       return o_sret_ack;
      default: return o_csr_ack;
    endcase
  endfunction

  task automatic wait_ack(input int which, input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (ack_of(which)) begin
        done = 1;
        break;
      end
    end
    if (!done) check($sformatf("ack_timeout_%0d", which), 96'(0), 96'(1));
  endtask

  task automatic drain(input int budget);
    bit done = 0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      check("drain_timeout", 96'(exp_q.size()), 96'(0));
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
    #2;
  endtask

  function automatic logic [31:0] trap_ss(input logic [31:0] s, input logic p);
    logic [31:0] r = s;
    r[5] = s[1];
    r[1] = 1'b0;
    r[8] = p;
    return r;
  endfunction

  function automatic logic [31:0] sret_ss(input logic [31:0] s);
    logic [31:0] r = s;
    r[1] = s[5];
    r[5] = 1'b1;
    r[8] = 1'b0;
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst_n       = 1'b0;
    csr_req     = 1'b0;
    csr_addr    = '0;
    csr_wdata   = '0;
    trap_req    = 1'b0;
    trap_pc     = '0;
    trap_cause  = '0;
    trap_tval   = '0;
    trap_priv_s = 1'b0;
    sret_req    = 1'b0;
    sstatus     = '0;
    stvec       = '0;
    sepc        = '0;

    // Reset state, with requests asserted to show they have no effect.
    #3;
    trap_req = 1'b1;
    csr_req  = 1'b1;
    #1;
    check("reset_outputs_a", 96'({o_csr_data, o_csr_select, o_csr_load, o_csr_ack,
                                  o_trap_ack, o_sret_ack, o_busy, o_redirect}), 96'(0));
    check("reset_redirect_pc", 96'(o_redirect_pc), 96'(0));
    trap_req = 1'b0;
    csr_req  = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("idle_busy", 96'(o_busy), 96'(0));

    // Full trap: operands change after acceptance and must not leak in.
    sstatus     = 32'h0000_0002;
    stvec       = 32'h8000_0203;
    trap_pc     = 32'h8000_0040;
    trap_cause  = 32'h0000_0008;
    trap_tval   = 32'h0000_ABCD;
    trap_priv_s = 1'b1;
    push_trap("trap", -1, 32'h8000_0040, 32'h8, 32'hABCD, 32'h0000_0120, 32'h8000_0200);
    trap_req = 1'b1;
    wait_ack(0, 10);
    trap_req    = 1'b0;
    check("trap_busy", 96'(o_busy), 96'(1));
    trap_pc     = 32'hFFFF_FFFF;
    trap_cause  = 32'h5555_5555;
    trap_tval   = 32'hAAAA_AAAA;
    trap_priv_s = 1'b0;
    drain(20);

    // sret
    sstatus = 32'h0000_0120;
    sepc    = 32'h8000_0105;
    push_sret("sret", -1, 32'h0000_0022, 32'h8000_0104);
    sret_req = 1'b1;
    wait_ack(1, 10);
    sret_req = 1'b0;
    drain(20);

    // Back-to-back CSR instruction writes: 2-cycle spacing.
    for (int i = 0; i < 5; i++) begin
      logic [11:0] a;
      logic [31:0] d;
      a = 12'($urandom);
      d = $urandom;
      push_csr($sformatf("csr%0d", i), (i == 0) ? -1 : 2, a, d);
      csr_addr  = a;
      csr_wdata = d;
      csr_req   = 1'b1;
      wait_ack(2, 10);
      csr_req = 1'b0;
    end
    drain(20);

    // All three requesters at once: trap, then sret, then CSR write.
    sstatus     = 32'h0000_0002;
    stvec       = 32'h0000_1001;
    sepc        = 32'h0000_3003;
    trap_pc     = 32'h0000_2000;
    trap_cause  = 32'h0000_0005;
    trap_tval   = 32'h0000_0077;
    trap_priv_s = 1'b0;
    csr_addr    = 12'h180;
    csr_wdata   = 32'h1234_5678;
    push_trap("all.trap", -1, 32'h2000, 32'h5, 32'h77, trap_ss(32'h2, 1'b0), 32'h0000_1000);
    push_sret("all.sret", 2, sret_ss(32'h2), 32'h0000_3002);
    push_csr("all.csr", 2, 12'h180, 32'h1234_5678);
    trap_req = 1'b1;
    sret_req = 1'b1;
    csr_req  = 1'b1;
    begin
      bit all_done = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #2;
        if (o_trap_ack) trap_req = 1'b0;
        if (o_sret_ack) sret_req = 1'b0;
        if (o_csr_ack)  csr_req  = 1'b0;
        if (!trap_req && !sret_req && !csr_req) begin
          all_done = 1;
          break;
        end
      end
      if (!all_done) check("all_ack_timeout", 96'({trap_req, sret_req, csr_req}), 96'(0));
      trap_req = 1'b0;
      sret_req = 1'b0;
      csr_req  = 1'b0;
    end
    drain(20);

    // CSR request raised mid-trap must wait for IDLE.
    sstatus     = 32'h0000_0000;
    stvec       = 32'h8000_0400;
    trap_pc     = 32'h8000_0010;
    trap_cause  = 32'h0000_0002;
    trap_tval   = 32'h0000_0000;
    trap_priv_s = 1'b1;
    push_trap("busy.trap", -1, 32'h8000_0010, 32'h2, 32'h0, 32'h0000_0100, 32'h8000_0400);
    push_csr("busy.csr", 2, 12'h305, 32'hDEAD_BEEF);
    trap_req = 1'b1;
    wait_ack(0, 10);
    trap_req = 1'b0;
    @(posedge clk);
    #2;
    csr_addr  = 12'h305;
    csr_wdata = 32'hDEAD_BEEF;
    csr_req   = 1'b1;
    wait_ack(2, 20);
    csr_req = 1'b0;
    drain(20);

    // Reset during T_STVAL: sepc and scause writes already issued, then
    // everything drops to zero at once and no redirect follows.
    sstatus     = 32'h0000_0002;
    stvec       = 32'h8000_0200;
    trap_pc     = 32'h8000_0100;
    trap_cause  = 32'h0000_000D;
    trap_tval   = 32'h0000_1234;
    trap_priv_s = 1'b1;
    push(EV_TRAP_ACK, 12'h000, 32'h0,          -1, "rst.ack");
    push(EV_WRITE,    12'h141, 32'h8000_0100,  0, "rst.sepc");
    push(EV_WRITE,    12'h142, 32'h0000_000D,  1, "rst.scause");
    trap_req = 1'b1;
    wait_ack(0, 10);
    trap_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2;
    check("rst_pre_stval_load", 96'({o_csr_load, o_csr_select}), 96'({1'b1, 12'h143}));
    rst_n = 1'b0;
    #1;
    check("rst_async_outputs", 96'({o_csr_data, o_csr_select, o_csr_load, o_csr_ack,
                                    o_trap_ack, o_sret_ack, o_busy, o_redirect}), 96'(0));
    check("rst_async_redirect_pc", 96'(o_redirect_pc), 96'(0));
    check("rst_pending_events", 96'(exp_q.size()), 96'(0));
    exp_q.delete();
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #2;
    check("post_rst_busy", 96'(o_busy), 96'(0));

    // Fresh traffic after reset still works.
    csr_addr  = 12'h141;
    csr_wdata = 32'h0BAD_F00D;
    push_csr("post_rst.csr", -1, 12'h141, 32'h0BAD_F00D);
    csr_req = 1'b1;
    wait_ack(2, 10);
    csr_req = 1'b0;
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/csr_trap_sequencer.md
# csr_trap_sequencer

Sequencer and single-port arbiter for the CPU's CSR file write port (`i_data`/`i_select`/`i_load`). It serialises three requester classes onto that one port: CSR-instruction writes, supervisor trap entry and `sret`. Trap entry needs four CSR writes and `sret` needs one. On completion of either, the block issues a PC redirect to the fetch stage.

## Interface
- `TRAP_WRITES`, 4: number of CSR writes in a trap-entry sequence. Fixed; documents the FSM length and is not meant to be overridden.
- `i_clk` in 1: system clock, rising edge.
- `i_rst_n` in 1: reset, asynchronous, active-low.
- `i_csr_req` in 1: CSR-instruction write request. Level; held until `o_csr_ack`.
- `i_csr_addr` in 12: CSR address for the instruction write.
- `i_csr_wdata` in 32: data for the instruction write.
- `i_trap_req` in 1: trap-entry request. Level; held until `o_trap_ack`.
- `i_trap_pc` in 32: faulting PC, written to `sepc`.
- `i_trap_cause` in 32: cause, written to `scause`.
- `i_trap_tval` in 32: trap value, written to `stval`.
- `i_trap_priv_s` in 1: privilege at trap time (1 = S). Becomes SPP.
- `i_sret_req` in 1: `sret` request. Level; held until `o_sret_ack`.
- `i_sstatus` in 32: current `sstatus` from the CSR file.
- `i_stvec` in 32: current `stvec` from the CSR file.
- `i_sepc` in 32: current `sepc` from the CSR file.
- `o_csr_data` out 32: to CSR file `i_data`.
- `o_csr_select` out 12: to CSR file `i_select`.
- `o_csr_load` out 1: to CSR file `i_load`.
- `o_csr_ack` out 1: one-cycle pulse when the instruction write is issued.
- `o_trap_ack` out 1: one-cycle pulse when a trap is accepted and its operands are latched.
- `o_sret_ack` out 1: one-cycle pulse when an `sret` is accepted.
- `o_busy` out 1: high in every non-IDLE state.
- `o_redirect` out 1: one-cycle pulse; fetch must load `o_redirect_pc`.
- `o_redirect_pc` out 32: redirect target. Valid only while `o_redirect` is high.

## Operation
- States: IDLE, WR_INSTR, T_SEPC, T_SCAUSE, T_STVAL, T_SSTATUS, T_REDIR, R_SSTATUS, R_REDIR.
- Arbitration applies in IDLE only. Priority is trap > sret > CSR instruction. The losing requests stay pending; they are not dropped.
- IDLE behaviour on each edge:
  - With `i_trap_req`: latch pc/cause/tval/priv_s, pulse `o_trap_ack`, go to T_SEPC.
  - Else with `i_sret_req`: pulse `o_sret_ack`, go to R_SSTATUS.
  - Else with `i_csr_req`: latch addr/wdata, go to WR_INSTR.
- WR_INSTR: drive `o_csr_load`=1 with the latched addr/data, pulse `o_csr_ack`, then go to IDLE.
- Trap chain, with `o_csr_load`=1 in each state:
  - T_SEPC writes 0x141 ← latched pc.
  - T_SCAUSE writes 0x142 ← cause.
  - T_STVAL writes 0x143 ← tval.
  - T_SSTATUS writes 0x100 ← new sstatus.
- New sstatus on trap entry:
  - Copy of `i_sstatus` as sampled in T_SSTATUS.
  - SPIE (bit 5) ← old SIE (bit 1).
  - SIE ← 0.
  - SPP (bit 8) ← latched priv_s.
  - All other bits unchanged.
- T_REDIR: `o_redirect`=1, `o_redirect_pc` = {`i_stvec`[31:2], 2'b00} (direct mode only; vectored mode is not supported). Then go to IDLE.
- New sstatus on `sret`, written in R_SSTATUS to 0x100:
  - SIE ← SPIE.
  - SPIE ← 1.
  - SPP ← 0.
  - Other bits unchanged.
- R_REDIR: `o_redirect`=1, `o_redirect_pc` = {`i_sepc`[31:1], 1'b0}. Then go to IDLE.
- In every state without a write: `o_csr_load`=0, `o_csr_select`=0, `o_csr_data`=0.
- Requests arriving while busy are ignored until the return to IDLE. They are then arbitrated fresh.

## Timing
- Reset value of every output is 0, with state = IDLE. Async assertion forces this immediately.
- Reset mid-sequence abandons the sequence. CSR writes already issued persist; no redirect is issued.
- Release of `i_rst_n` is synchronised by the integrator. The first arbitration happens on the first edge after release.
- All outputs are decoded from registered state and latched operands; there is no combinational path from request inputs to outputs.
- Acks are asserted during the first cycle after the accepting edge.
- Latency from accepting edge to the write cycle or redirect pulse:
  - CSR instruction write: 1 cycle.
  - Trap: 5 cycles to the redirect pulse (writes in cycles 1–4).
  - `sret`: 2 cycles to the redirect pulse.
- The minimum gap between back-to-back CSR instruction writes is 2 cycles (IDLE, WR_INSTR).
- Trap operands are latched at acceptance; later input changes do not affect the sequence.
- `i_sstatus`, `i_stvec` and `i_sepc` are sampled live. The CSR file's 1-cycle write latency makes `sepc` (written in T_SEPC) visible long before any later read.

## Test plan
- Reset during T_STVAL:
  - Setup: trap cause=0xD, pc=0x8000_0100, tval=0x1234, `i_sstatus`=0x2.
  - Expected before reset: writes 0x141=0x8000_0100, 0x142=0xD.
  - Expected on reset: all outputs go to 0 immediately, with no redirect.
- Full trap:
  - Stimulus: `i_sstatus`=0x0000_0002, priv_s=1, `i_stvec`=0x8000_0203.
  - Expected: `o_trap_ack` pulse, then 4 write cycles ending with 0x100=0x0000_0120.
  - Then `o_redirect`=1 with pc=0x8000_0200, 5 cycles after acceptance.
- `sret`:
  - Stimulus: `i_sstatus`=0x0000_0120, `i_sepc`=0x8000_0105.
  - Expected: write 0x100=0x0000_0022, then redirect to 0x8000_0104.
- Simultaneous `i_trap_req`, `i_sret_req` and `i_csr_req` in IDLE:
  - Trap completes first; then `sret`; then the CSR write.
  - Each gets exactly one ack pulse.
- `i_csr_req` addr=0x305, data=0xDEAD_BEEF asserted while busy mid-trap:
  - Expected: no load until IDLE.
  - Then a single cycle with `o_csr_load`=1, select=0x305, data=0xDEAD_BEEF, and `o_csr_ack`=1.
